// File: rtl/key_pkg.sv
// key_pkg: shared FSM encoding and default timing constants for the key filter.
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_FILT, HELD, REL_FILT} key_st_t;
  localparam logic [31:0] CNT_MAX_DEF  = 32'd1_000_000;
  localparam logic [31:0] LONG_MAX_DEF = 32'd50_000_000;
endpackage

// File: rtl/key_filter_ch.sv
// key_filter_ch: single-channel key synchronizer, debouncer and press/release/long-press strobes.
// Long-press detection is built only when KEY_FILTER_LONG_PRESS_EN is defined.
module key_filter_ch
  import key_pkg::*;
#(
  parameter logic [31:0] CNT_MAX  = CNT_MAX_DEF,
  parameter logic [31:0] LONG_MAX = LONG_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  logic s1, s2, pp_nx, rp_nx;
  key_st_t st, nx;
  logic [31:0] cnt, cnt_nx, cnt_inc;
`ifdef KEY_FILTER_LONG_PRESS_EN
  logic lp_nx;
`endif
  assign cnt_inc = cnt + {31'd0, ~&cnt};
  always_comb begin
    nx = st;
    cnt_nx = cnt;
    pp_nx = 1'b0;
    rp_nx = 1'b0;
`ifdef KEY_FILTER_LONG_PRESS_EN
    lp_nx = 1'b0;
`endif
    case (st)
      IDLE: if (!s2) begin
        nx = PRESS_FILT;
        cnt_nx = '0;
      end
      PRESS_FILT: if (s2) begin
        nx = IDLE;
        cnt_nx = '0;
      end else if (cnt == CNT_MAX - 32'd1) begin
        nx = HELD;
        cnt_nx = '0;
        pp_nx = 1'b1;
      end else cnt_nx = cnt_inc;
      HELD: if (s2) begin
        nx = REL_FILT;
        cnt_nx = '0;
      end
`ifdef KEY_FILTER_LONG_PRESS_EN
      else if (cnt != LONG_MAX) begin
        cnt_nx = cnt + 32'd1;
        lp_nx = (cnt == LONG_MAX - 32'd1);
      end
`endif
      REL_FILT: if (!s2) begin
        nx = HELD;
        cnt_nx = '0;
      end else if (cnt == CNT_MAX - 32'd1) begin
        nx = IDLE;
        cnt_nx = '0;
        rp_nx = 1'b1;
      end else cnt_nx = cnt_inc;
      default: begin
        nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      st <= IDLE;
      cnt <= '0;
      key_state <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
      st <= nx;
      cnt <= cnt_nx;
      key_state <= (nx == HELD) || (nx == REL_FILT);
      press_pulse <= pp_nx;
      release_pulse <= rp_nx;
    end
`ifdef KEY_FILTER_LONG_PRESS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) long_pulse <= 1'b0;
    else long_pulse <= lp_nx;
`else
  logic unused_long;
  assign unused_long = ^LONG_MAX;
  assign long_pulse = 1'b0;
`endif
endmodule

// File: rtl/key_filter_multi.sv
// key_filter_multi: KEY_NUM independent debounced key channels with press/release/long-press strobes.
// Long-press strobes exist only when KEY_FILTER_LONG_PRESS_EN is defined.
module key_filter_multi
  import key_pkg::*;
#(
  parameter int          KEY_NUM  = 4,
  parameter logic [31:0] CNT_MAX  = CNT_MAX_DEF,
  parameter logic [31:0] LONG_MAX = LONG_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] press_pulse,
  output logic [KEY_NUM-1:0] release_pulse,
  output logic [KEY_NUM-1:0] long_pulse
);
  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_filter_ch #(.CNT_MAX(CNT_MAX), .LONG_MAX(LONG_MAX)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .key(key[i]),
      .key_state(key_state[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse(long_pulse[i])
    );
  end
endmodule

// File: tb/tb_key_filter_multi.sv
// tb_key_filter_multi: vector table, directed corner sequences and random stimulus against a run-length debounce model.
module tb_key_filter_multi;
  localparam int N = 4;
  localparam int CNT = 20;
  localparam int LNG = 100;
`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] key = '1;
  logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse;
  int tests = 0;
  int fails = 0;
  key_filter_multi #(.KEY_NUM(N), .CNT_MAX(32'd20), .LONG_MAX(32'd100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .key_state(key_state),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: a debounced level flips after CNT+1 consecutive synchronized samples that disagree with it.
  bit q1[N], q2[N], db[N];
  int run[N], held[N];
  logic [N-1:0] e_st, e_p, e_r, e_l;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        q1[i] = 1; q2[i] = 1; db[i] = 0; run[i] = 0; held[i] = -1;
      end
      e_st = '0; e_p = '0; e_r = '0; e_l = '0;
    end else
      for (int i = 0; i < N; i++) begin
        bit ks;
        ks = q2[i]; q2[i] = q1[i]; q1[i] = key[i];
        e_p[i] = 0; e_r[i] = 0; e_l[i] = 0;
        if (!db[i]) begin
          run[i] = ks ? 0 : run[i] + 1;
          if (run[i] == CNT + 1) begin
            db[i] = 1; e_p[i] = 1; run[i] = 0; held[i] = 0;
          end
        end else if (ks) begin
          run[i]++;
          held[i] = -1;
          if (run[i] == CNT + 1) begin
            db[i] = 0; e_r[i] = 1; run[i] = 0;
          end
        end else begin
          run[i] = 0;
          if (held[i] < 0) held[i] = 0;
          else begin
            held[i]++;
            if (LONG_EN && held[i] == LNG) e_l[i] = 1;
          end
        end
        e_st[i] = db[i];
      end
  int cnt_p[N], cnt_r[N], cnt_l[N];
  logic [N-1:0] ever_st;
  always @(negedge clk) begin
    chk("model key_state", int'(key_state), int'(e_st));
    chk("model press_pulse", int'(press_pulse), int'(e_p));
    chk("model release_pulse", int'(release_pulse), int'(e_r));
    chk("model long_pulse", int'(long_pulse), int'(e_l));
    for (int i = 0; i < N; i++) begin
      cnt_p[i] += int'(press_pulse[i]);
      cnt_r[i] += int'(release_pulse[i]);
      cnt_l[i] += int'(long_pulse[i]);
    end
    ever_st |= key_state;
  end
  task automatic clr;
    for (int i = 0; i < N; i++) begin
      cnt_p[i] = 0; cnt_r[i] = 0; cnt_l[i] = 0;
    end
    ever_st = '0;
  endtask
  // Edges after the first sampling edge until the chosen strobe is seen; -1 on timeout.
  task automatic wait_pulse(input int ch, input int kind, input int bound, output int n);
    logic s;
    n = -1;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      s = kind == 0 ? press_pulse[ch] : kind == 1 ? release_pulse[ch] : long_pulse[ch];
      if (s) return;
    end
    n = -1;
  endtask
  typedef struct {int ch; int low; int press; int lng;} vec_t;
  vec_t tv[7];
  int rem[N];
  int n, m;
  initial begin
    tv[0] = '{0, 10, 0, 0};
    tv[1] = '{1, 20, 0, 0};
    tv[2] = '{2, 21, 1, 0};
    tv[3] = '{3, 22, 1, 0};
    tv[4] = '{1, 120, 1, 0};
    tv[5] = '{2, 121, 1, 1};
    tv[6] = '{3, 150, 1, 1};
    clr();
    repeat (4) @(negedge clk);
    chk("reset outputs", int'({key_state, press_pulse, release_pulse, long_pulse}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int t = 0; t < 7; t++) begin
      clr();
      key[tv[t].ch] = 1'b0;
      repeat (tv[t].low) @(negedge clk);
      key[tv[t].ch] = 1'b1;
      repeat (40) @(negedge clk);
      chk($sformatf("vec%0d press count", t), cnt_p[tv[t].ch], tv[t].press);
      chk($sformatf("vec%0d release count", t), cnt_r[tv[t].ch], tv[t].press);
      chk($sformatf("vec%0d long count", t), cnt_l[tv[t].ch], LONG_EN ? tv[t].lng : 0);
    end
    clr();
    key[0] = 1'b0;
    wait_pulse(0, 0, 100, n);
    chk("clean press latency", n, 22);
    chk("clean press key_state", int'(key_state[0]), 1);
    @(negedge clk);
    chk("clean press one cycle", int'(press_pulse[0]), 0);
    key[0] = 1'b1;
    repeat (5) @(negedge clk);
    key[0] = 1'b0;
    repeat (3) @(negedge clk);
    key[0] = 1'b1;
    wait_pulse(0, 1, 100, n);
    chk("glitch release latency", n, 22);
    repeat (40) @(negedge clk);
    chk("glitch release count", cnt_r[0], 1);
    clr();
    key[1] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      key[1] = ~key[1];
      repeat (5) @(negedge clk);
    end
    key[1] = 1'b1;
    repeat (40) @(negedge clk);
    chk("bounce pulses", cnt_p[1] + cnt_r[1] + cnt_l[1], 0);
    chk("bounce key_state", int'(ever_st[1]), 0);
    key[2] = 1'b0;
    wait_pulse(2, 0, 100, n);
    chk("long press latency", n, 22);
    wait_pulse(2, 2, 150, m);
    chk("long after press", m, LONG_EN ? 99 : -1);
    key[2] = 1'b1;
    repeat (40) @(negedge clk);
    key[0] = 1'b0;
    repeat (30) @(negedge clk);
    key[3] = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("reset mid-press outputs", int'({key_state, press_pulse, release_pulse, long_pulse}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(3, 0, 100, n);
    chk("post-reset press latency", n, 22);
    chk("post-reset ch0 repress", int'(press_pulse[0]), 1);
    key[0] = 1'b1;
    key[3] = 1'b1;
    repeat (40) @(negedge clk);
    clr();
    key[0] = 1'b0;
    key[3] = 1'b0;
    wait_pulse(0, 0, 100, n);
    chk("concurrent ch0 latency", n, 22);
    chk("concurrent ch3 press", int'(press_pulse[3]), 1);
    chk("concurrent idle channels", int'({key_state[2:1], press_pulse[2:1]}), 0);
    key = '1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (rem[i] == 0) begin
          key[i] = ~key[i];
          rem[i] = $urandom_range(0, 3) == 0 ? $urandom_range(20, 140) : $urandom_range(1, 25);
        end else rem[i]--;
      if (c == 1500) begin
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end else @(negedge clk);
    end
    key = '1;
    repeat (60) @(negedge clk);
    chk("final idle", int'(key_state), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
